// File: rtl/dmem_bridge_pkg.sv
// Shared types and codes for the MEM-stage data-bus bridge.
// Holds the FSM state encoding, access size codes and the kseg0/kseg1 window test.
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // kseg0 (0x8000_0000) and kseg1 (0xA000_0000) share addr[31:30] = 2'b10
    function automatic logic is_kseg01(input logic [31:0] vaddr);
        return vaddr[31:30] == 2'b10;
    endfunction

endpackage

// File: rtl/dmem_bridge_addr_map.sv
// Combinational virtual-to-physical translation for the data bus.
// With KSEG_MAP set, kseg0/kseg1 addresses drop their top three bits; all else passes through.
module addr_map
    import dmem_bridge_pkg::*;
#(
    parameter int KSEG_MAP = 1
) (
    input  logic [31:0] vaddr,
    output logic [31:0] paddr
);

    always_comb begin
        paddr = vaddr;
        if ((KSEG_MAP != 0) && is_kseg01(vaddr)) begin
            paddr[31:29] = '0;
        end
    end

endmodule

// File: rtl/dmem_bridge.sv
// MEM-stage to request/ack data-bus bridge: one outstanding access, pipeline held until data returns.
// Request fields are registered on issue so the bus sees them stable while d_req is high.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int KSEG_MAP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  sel,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_excepttype,
    input  logic        other_stall,
    output logic [31:0] mem_rdata,
    output logic        stallreq_from_mem,
    output logic        d_req,
    output logic        d_wr,
    output logic [1:0]  d_size,
    output logic [31:0] d_addr,
    output logic [31:0] d_wdata,
    output logic [3:0]  d_wstrb,
    input  logic        d_addr_ok,
    input  logic        d_data_ok,
    input  logic [31:0] d_rdata
);

    state_t      state;
    state_t      state_next;
    logic        pending;
    logic        capture;
    logic        latch_rdata;
    logic [31:0] paddr;

    assign pending = mem_en && (mem_excepttype == '0);

    addr_map #(
        .KSEG_MAP (KSEG_MAP)
    ) u_addr_map (
        .vaddr (mem_addr),
        .paddr (paddr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            d_wr      <= 1'b0;
            d_size    <= '0;
            d_addr    <= '0;
            d_wdata   <= '0;
            d_wstrb   <= '0;
            mem_rdata <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                d_wr    <= mem_we;
                d_size  <= mem_size;
                d_addr  <= paddr;
                d_wdata <= mem_wdata;
                d_wstrb <= mem_we ? sel : 4'b0000;
            end
            if (latch_rdata) begin
                mem_rdata <= d_rdata;
            end
        end
    end

    always_comb begin
        state_next  = state;
        capture     = 1'b0;
        latch_rdata = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pending) begin
                    state_next = ST_REQ;
                    capture    = 1'b1;
                end
            end
            ST_REQ: begin
                if (d_addr_ok) begin
                    if (d_data_ok) begin
                        latch_rdata = 1'b1;
                        state_next  = ST_DONE;
                    end else begin
                        state_next  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (d_data_ok) begin
                    latch_rdata = 1'b1;
                    state_next  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!other_stall) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign d_req = (state == ST_REQ);

    // DONE deliberately releases the stall so the pipeline moves past this access
    assign stallreq_from_mem = !rst && (((state == ST_IDLE) && pending)
                                        || (state == ST_REQ)
                                        || (state == ST_WAIT));

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: table of single transactions plus hand-written
// sequences for exception suppression, held DONE and reset mid-transaction.
module tb_dmem_bridge;
    import dmem_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  sel;
    logic [1:0]  mem_size;
    logic [31:0] mem_excepttype;
    logic        other_stall;
    logic [31:0] mem_rdata;
    logic        stallreq_from_mem;
    logic        d_req;
    logic        d_wr;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_addr_ok;
    logic        d_data_ok;
    logic [31:0] d_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_bridge #(
        .KSEG_MAP (1)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_en            (mem_en),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .sel               (sel),
        .mem_size          (mem_size),
        .mem_excepttype    (mem_excepttype),
        .other_stall       (other_stall),
        .mem_rdata         (mem_rdata),
        .stallreq_from_mem (stallreq_from_mem),
        .d_req             (d_req),
        .d_wr              (d_wr),
        .d_size            (d_size),
        .d_addr            (d_addr),
        .d_wdata           (d_wdata),
        .d_wstrb           (d_wstrb),
        .d_addr_ok         (d_addr_ok),
        .d_data_ok         (d_data_ok),
        .d_rdata           (d_rdata)
    );

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [1:0]  size;
        int unsigned addr_delay;
        int unsigned data_lat;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_wstrb;
        int unsigned exp_stall;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v);
        int unsigned stalls = 0;
        int unsigned req_cycles = 0;
        int unsigned waited = 0;
        logic        accepted = 1'b0;
        logic        done = 1'b0;
        logic        stable = 1'b1;
        @(negedge clk);
        mem_en = 1'b1; mem_we = v.we; mem_addr = v.addr; mem_wdata = v.wdata;
        sel = v.sel; mem_size = v.size; mem_excepttype = '0; other_stall = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) @(negedge clk);
            d_addr_ok = 1'b0;
            d_data_ok = 1'b0;
            d_rdata   = 32'h5555_AAAA;
            if (c == 2) begin
                // pipeline-side inputs move; the registered request must not
                mem_addr = ~v.addr; mem_wdata = ~v.wdata; sel = ~v.sel;
                mem_excepttype = 32'h0000_0010;
            end
            if (d_req) begin
                if (req_cycles == 0) begin
                    check({v.name, ".d_addr"},  d_addr,  v.exp_addr);
                    check({v.name, ".d_wr"},    {31'b0, d_wr},    {31'b0, v.we});
                    check({v.name, ".d_size"},  {30'b0, d_size},  {30'b0, v.size});
                    check({v.name, ".d_wdata"}, d_wdata, v.wdata);
                    check({v.name, ".d_wstrb"}, {28'b0, d_wstrb}, {28'b0, v.exp_wstrb});
                end else if (d_addr !== v.exp_addr || d_wdata !== v.wdata
                             || d_wstrb !== v.exp_wstrb || d_wr !== v.we || d_size !== v.size) begin
                    stable = 1'b0;
                end
                if (req_cycles == v.addr_delay) begin
                    d_addr_ok = 1'b1;
                    accepted  = 1'b1;
                    if (v.data_lat == 0) begin
                        d_data_ok = 1'b1;
                        d_rdata   = v.rdata;
                    end
                end
                req_cycles++;
            end else if (accepted) begin
                waited++;
                if (waited >= v.data_lat) begin
                    d_data_ok = 1'b1;
                    d_rdata   = v.rdata;
                end
            end
            #1;
            if (stallreq_from_mem) stalls++;
            else done = 1'b1;
        end
        check({v.name, ".completed"}, {31'b0, done}, 32'd1);
        check({v.name, ".stall_cycles"}, stalls, v.exp_stall);
        check({v.name, ".req_cycles"}, req_cycles, v.addr_delay + 1);
        check({v.name, ".req_stable"}, {31'b0, stable}, 32'd1);
        check({v.name, ".mem_rdata"}, mem_rdata, v.rdata);
        d_addr_ok = 1'b0; d_data_ok = 1'b0;
        mem_en = 1'b0; mem_excepttype = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned reqs;
        logic        done;

        vecs[0] = '{"word_load_kseg1", 32'hBFC0_0010, 1'b0, 32'h0000_0000, 4'b1111, SIZE_WORD,
                    0, 1, 32'h1234_5678, 32'h1FC0_0010, 4'b0000, 3};
        vecs[1] = '{"byte_store_kseg0", 32'h8000_1002, 1'b1, 32'h00AB_0000, 4'b0100, SIZE_BYTE,
                    0, 0, 32'h5A5A_5A5A, 32'h0000_1002, 4'b0100, 2};
        vecs[2] = '{"half_store_kuseg", 32'h0040_0006, 1'b1, 32'hBEEF_0000, 4'b1100, SIZE_HALF,
                    2, 1, 32'h0000_0001, 32'h0040_0006, 4'b1100, 5};
        vecs[3] = '{"load_kseg2_slow", 32'hC000_0000, 1'b0, 32'h1111_2222, 4'b1111, SIZE_WORD,
                    10, 1, 32'hCAFE_F00D, 32'hC000_0000, 4'b0000, 13};
        vecs[4] = '{"load_kseg1_fast", 32'hA000_0020, 1'b0, 32'h0000_0000, 4'b1111, SIZE_WORD,
                    0, 0, 32'h8765_4321, 32'h0000_0020, 4'b0000, 2};

        rst = 1'b1; mem_en = 1'b1; mem_we = 1'b0; mem_addr = 32'h8000_0000;
        mem_wdata = '0; sel = '0; mem_size = '0; mem_excepttype = '0;
        other_stall = 1'b0; d_addr_ok = 1'b0; d_data_ok = 1'b0; d_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("reset.stall", {31'b0, stallreq_from_mem}, 32'd0);
        check("reset.d_req", {31'b0, d_req}, 32'd0);
        check("reset.d_addr", d_addr, 32'd0);
        check("reset.fields", {d_wdata[29:0], d_wr, d_size[0]} | {28'b0, d_wstrb} | {30'b0, d_size},
              32'd0);
        check("reset.mem_rdata", mem_rdata, 32'd0);
        mem_en = 1'b0;
        @(negedge clk); rst = 1'b0;

        // excepting instruction never reaches the bus
        @(negedge clk);
        mem_en = 1'b1; mem_excepttype = 32'h0000_0004;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("except.stall", {31'b0, stallreq_from_mem}, 32'd0);
            check("except.d_req", {31'b0, d_req}, 32'd0);
            @(negedge clk);
        end
        mem_en = 1'b0; mem_excepttype = '0;

        for (int i = 0; i < 5; i++) run_txn(vecs[i]);

        // completion under external stall: DONE held, single request, data stable
        @(negedge clk);
        mem_en = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_1000; mem_size = SIZE_WORD;
        sel = 4'b1111; other_stall = 1'b1;
        reqs = 0; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (c > 0) @(negedge clk);
            d_addr_ok = d_req; d_data_ok = d_req;
            d_rdata = d_req ? 32'h0F0F_1234 : 32'h0;
            if (d_req) reqs++;
            #1;
            done = !stallreq_from_mem;
        end
        check("hold.reached_done", {31'b0, done}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            d_addr_ok = 1'b0; d_data_ok = 1'b1; d_rdata = 32'hBAD0_BAD0;
            if (d_req) reqs++;
            #1;
            check("hold.stall", {31'b0, stallreq_from_mem}, 32'd0);
            check("hold.mem_rdata", mem_rdata, 32'h0F0F_1234);
        end
        @(negedge clk);
        d_data_ok = 1'b0; other_stall = 1'b0;
        if (d_req) reqs++;
        #1;
        check("hold.mem_rdata_last", mem_rdata, 32'h0F0F_1234);
        @(negedge clk);
        mem_en = 1'b0;
        if (d_req) reqs++;
        #1;
        check("hold.idle_stall", {31'b0, stallreq_from_mem}, 32'd0);
        check("hold.req_count", reqs, 32'd1);

        // reset in WAIT abandons the access; a late data_ok is ignored
        @(negedge clk);
        mem_en = 1'b1; mem_addr = 32'h0000_2000; mem_we = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 10 && !done; c++) begin
            if (c > 0) @(negedge clk);
            d_addr_ok = d_req; d_data_ok = 1'b0;
            done = d_req;
        end
        check("rstwait.issued", {31'b0, done}, 32'd1);
        @(negedge clk);
        d_addr_ok = 1'b0;
        #1;
        check("rstwait.in_wait", {30'b0, stallreq_from_mem, d_req}, 32'd2);
        rst = 1'b1;
        #1;
        check("rstwait.stall_in_reset", {31'b0, stallreq_from_mem}, 32'd0);
        @(negedge clk);
        rst = 1'b0; mem_en = 1'b0;
        @(negedge clk);
        d_data_ok = 1'b1; d_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        d_data_ok = 1'b0; d_rdata = '0;
        #1;
        check("rstwait.mem_rdata", mem_rdata, 32'd0);
        check("rstwait.stall", {31'b0, stallreq_from_mem}, 32'd0);
        check("rstwait.d_req", {31'b0, d_req}, 32'd0);
        @(negedge clk);
        #1;
        check("rstwait.idle_rdata", mem_rdata, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
